uart_rx_sampler_n: RTL and testbench

Parametrised oversampling bit sampler for the UART receiver. It sits between the RX edge/bit counter and the deserializer and parity/stop checkers. It captures NSAMP consecutive samples of RX_IN centred on the bit midpoint, then emits the majority-vote bit with a one-cycle ready pulse. It also flags disagreeing sample windows as noise, counts them, and guards against prescale settings that cannot fit the window.

---
 rtl/uart_rx_pkg.sv | 50 +++++
 rtl/uart_rx_sampler_n_if.sv | 20 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_sampler_n.sv | 119 +++++++++++
 tb/tb_uart_rx_sampler_n.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: sample-count limits, majority vote and
// the mid-bit sampling window shared with the RX edge counter.
package uart_rx_pkg;

  localparam int NSAMP_MAX = 7;

  typedef struct packed {
    logic maj;
    logic unanimous;
  } vote_t;

  typedef struct packed {
    logic [15:0] first;
    logic [15:0] last;
    logic        err;
  } window_t;

  function automatic logic nsamp_legal(input int n);
    return (n >= 1) && (n <= NSAMP_MAX) && ((n % 2) == 1);
  endfunction

  // Only the low n bits of samples take part in the vote.
  function automatic vote_t maj_vote(input logic [NSAMP_MAX-1:0] samples, input int n);
    vote_t v;
    int    ones;
    ones = 0;
    for (int i = 0; i < NSAMP_MAX; i++) begin
      if (i < n && samples[i]) ones++;
    end
    v.maj       = (ones > (n - 1) / 2);
    v.unanimous = (ones == 0) || (ones == n);
    return v;
  endfunction

  // Signed int arithmetic so that mid-half and prescale-1 never wrap.
  function automatic window_t window_bounds(input logic [15:0] prescale, input int n);
    window_t w;
    int      p;
    int      mid;
    int      half;
    p       = int'(prescale);
    mid     = p / 2;
    half    = (n - 1) / 2;
    w.err   = (mid < half) || (mid + half > p - 1) || (p < 2);
    w.first = w.err ? 16'd0 : 16'(mid - half);
    w.last  = w.err ? 16'd0 : 16'(mid + half);
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_n_if.sv
// Sampling handshake between the RX control FSM (master) and the bit sampler (slave).
interface uart_rx_sampler_n_if #(
  parameter int EDGE_W = 5
);
  logic              data_samp_en;
  logic [EDGE_W-1:0] edge_cnt;
  logic              sampled_bit;
  logic              bit_ready;
  logic              noise_flag;

  modport master (
    output data_samp_en, edge_cnt,
    input  sampled_bit, bit_ready, noise_flag
  );

  modport slave (
    input  data_samp_en, edge_cnt,
    output sampled_bit, bit_ready, noise_flag
  );
endinterface

// File: rtl/uart_rx_sync.sv
// RX_IN synchronizer: STAGES flops reset to the idle-high line level.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  if (STAGES == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_chain
    logic [STAGES-1:0] chain_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) chain_reg[gi] <= 1'b1;
          else      chain_reg[gi] <= din;
        end
      end else begin : g_tail
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) chain_reg[gi] <= 1'b1;
          else      chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end

    assign dout = chain_reg[STAGES-1];
  end

endmodule

// File: rtl/uart_rx_sampler_n.sv
// Oversampling bit sampler: captures NSAMP samples around the bit midpoint,
// emits the majority bit with a ready pulse and tracks noisy windows.
module uart_rx_sampler_n
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int EDGE_W      = 5,
  parameter int NSAMP       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int NOISE_CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESCALE_W-1:0]  Prescale,
  input  logic                   noise_clr,
  uart_rx_sampler_n_if.slave     samp,
  output logic [NOISE_CNT_W-1:0] noise_cnt,
  output logic                   cfg_err
);

  localparam logic NSAMP_OK = nsamp_legal(NSAMP);
  // An illegal NSAMP keeps the datapath sized for one slot and holds cfg_err high.
  localparam int   NS       = NSAMP_OK ? NSAMP : 1;

  logic                   rx_s;
  window_t                win;
  logic [EDGE_W-1:0]      edge_cur;
  logic [15:0]            edge_ext;
  logic                   capture_en;
  logic [NS-1:0]          hit;
  logic [NS-1:0]          slots_reg;
  logic [NS-1:0]          valid_reg;
  logic [NSAMP_MAX-1:0]   vote_vec;
  logic                   is_last;
  logic                   window_full;
  logic                   noisy_vote;
  vote_t                  vote;
  logic                   sampled_bit_reg;
  logic                   bit_ready_reg;
  logic                   noise_flag_reg;
  logic [NOISE_CNT_W-1:0] noise_cnt_reg;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .din  (RX_IN),
    .dout (rx_s)
  );

  assign win        = window_bounds(16'(Prescale), NS);
  assign cfg_err    = win.err || !NSAMP_OK;
  assign edge_cur   = samp.edge_cnt;
  assign edge_ext   = 16'(edge_cur);
  assign capture_en = samp.data_samp_en && !cfg_err;

  for (genvar gi = 0; gi < NS; gi++) begin : g_slot
    assign hit[gi] = capture_en && (edge_ext == win.first + 16'(gi));
  end

  // The top slot always comes straight from rx_s so the last sample is never stale.
  for (genvar gi = 0; gi < NSAMP_MAX; gi++) begin : g_vote
    if (gi == NS - 1) begin : g_live
      assign vote_vec[gi] = rx_s;
    end else if (gi < NS - 1) begin : g_stored
      assign vote_vec[gi] = slots_reg[gi];
    end else begin : g_unused
      assign vote_vec[gi] = 1'b0;
    end
  end

  assign is_last     = hit[NS-1];
  assign window_full = &(valid_reg | hit);
  assign vote        = maj_vote(vote_vec, NS);
  assign noisy_vote  = is_last && window_full && !vote.unanimous;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      slots_reg       <= '1;
      valid_reg       <= '0;
      sampled_bit_reg <= 1'b1;
      bit_ready_reg   <= 1'b0;
      noise_flag_reg  <= 1'b0;
    end else begin
      bit_ready_reg  <= 1'b0;
      noise_flag_reg <= 1'b0;
      if (!samp.data_samp_en) begin
        valid_reg <= '0;
      end else if (is_last) begin
        valid_reg <= '0;
        if (window_full) begin
          sampled_bit_reg <= vote.maj;
          bit_ready_reg   <= 1'b1;
          noise_flag_reg  <= !vote.unanimous;
        end
      end else if (|hit) begin
        // Landing on the first slot opens a fresh window, dropping any leftovers.
        valid_reg <= (hit[0] ? '0 : valid_reg) | hit;
        slots_reg <= (slots_reg & ~hit) | (hit & {NS{rx_s}});
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      noise_cnt_reg <= '0;
    end else if (noise_clr) begin
      noise_cnt_reg <= '0;
    end else if (noisy_vote && (noise_cnt_reg != '1)) begin
      noise_cnt_reg <= noise_cnt_reg + 1'b1;
    end
  end

  assign samp.sampled_bit = sampled_bit_reg;
  assign samp.bit_ready   = bit_ready_reg;
  assign samp.noise_flag  = noise_flag_reg;
  assign noise_cnt        = noise_cnt_reg;

endmodule

// File: tb/tb_uart_rx_sampler_n.sv
// Bench for uart_rx_sampler_n: three NSAMP variants share one stimulus stream
// and are checked every cycle against a window-level reference model.
module tb_uart_rx_sampler_n;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       noise_clr = 1'b0;
  logic [5:0] Prescale = 6'd8;

  always #5 CLK = ~CLK;

  uart_rx_sampler_n_if #(.EDGE_W(5)) if3 ();
  uart_rx_sampler_n_if #(.EDGE_W(5)) if5 ();
  uart_rx_sampler_n_if #(.EDGE_W(5)) if7 ();

  logic [7:0] nc3, nc5, nc7;
  logic       ce3, ce5, ce7;

  uart_rx_sampler_n #(.NSAMP(3)) dut3 (.CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .noise_clr(noise_clr), .samp(if3), .noise_cnt(nc3), .cfg_err(ce3));
  uart_rx_sampler_n #(.NSAMP(5)) dut5 (.CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .noise_clr(noise_clr), .samp(if5), .noise_cnt(nc5), .cfg_err(ce5));
  uart_rx_sampler_n #(.NSAMP(7)) dut7 (.CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .noise_clr(noise_clr), .samp(if7), .noise_cnt(nc7), .cfg_err(ce7));

  logic       ob_bit [3];
  logic       ob_rdy [3];
  logic       ob_nf  [3];
  logic [7:0] ob_cnt [3];
  logic       ob_ce  [3];

  assign ob_bit[0] = if3.sampled_bit; assign ob_rdy[0] = if3.bit_ready; assign ob_nf[0] = if3.noise_flag;
  assign ob_bit[1] = if5.sampled_bit; assign ob_rdy[1] = if5.bit_ready; assign ob_nf[1] = if5.noise_flag;
  assign ob_bit[2] = if7.sampled_bit; assign ob_rdy[2] = if7.bit_ready; assign ob_nf[2] = if7.noise_flag;
  assign ob_cnt[0] = nc3; assign ob_cnt[1] = nc5; assign ob_cnt[2] = nc7;
  assign ob_ce[0]  = ce3; assign ob_ce[1]  = ce5; assign ob_ce[2]  = ce7;

  // One entry per clock: rx is the value the sampler must see on its synchronized line.
  typedef struct {
    bit en;
    int edge_v;
    bit rx;
    bit clr;
    bit rst_n;
    int presc;
  } cyc_t;

  cyc_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   ns_tab[3]  = '{3, 5, 7};

  bit m_valid [3][7];
  bit m_samp  [3][7];
  bit m_bit   [3];
  bit m_rdy   [3];
  bit m_nf    [3];
  int m_cnt   [3];

  task automatic push(input bit en, input int e, input bit rx, input bit clr, input bit rst_n, input int presc);
    cyc_t c;
    c.en = en; c.edge_v = e; c.rx = rx; c.clr = clr; c.rst_n = rst_n; c.presc = presc;
    q.push_back(c);
  endtask

  task automatic add_idle(input int n, input bit rst_n, input int presc);
    for (int i = 0; i < n; i++) push(1'b0, 0, 1'b1, 1'b0, rst_n, presc);
  endtask

  task automatic add_window(input int presc, input logic [31:0] pat, input int cut, input int clr_at);
    for (int e = 0; e < presc; e++)
      push((cut < 0) || (e < cut), e, pat[e], e == clr_at, 1'b1, presc);
  endtask

  function automatic bit cfg_bad(input int p, input int n);
    int mid;
    int half;
    mid  = p / 2;
    half = (n - 1) / 2;
    return (p < 2) || (mid < half) || (mid + half > p - 1);
  endfunction

  task automatic model_step(input cyc_t c);
    for (int k = 0; k < 3; k++) begin
      int n, half, first, last, ones;
      bit complete;
      n     = ns_tab[k];
      half  = (n - 1) / 2;
      first = c.presc / 2 - half;
      last  = c.presc / 2 + half;
      m_rdy[k] = 1'b0;
      m_nf[k]  = 1'b0;
      if (!c.rst_n) begin
        m_bit[k] = 1'b1;
        m_cnt[k] = 0;
        for (int i = 0; i < 7; i++) begin m_valid[k][i] = 1'b0; m_samp[k][i] = 1'b1; end
      end else begin
        if (!c.en) begin
          for (int i = 0; i < 7; i++) m_valid[k][i] = 1'b0;
        end else if (!cfg_bad(c.presc, n) && c.edge_v >= first && c.edge_v <= last) begin
          if (c.edge_v == last) begin
            complete = 1'b1;
            ones     = int'(c.rx);
            for (int i = 0; i < n - 1; i++) begin
              complete = complete & m_valid[k][i];
              ones     = ones + int'(m_samp[k][i]);
            end
            if (complete) begin
              m_bit[k] = (ones > half);
              m_rdy[k] = 1'b1;
              m_nf[k]  = (ones != 0) && (ones != n);
            end
            for (int i = 0; i < 7; i++) m_valid[k][i] = 1'b0;
          end else begin
            if (c.edge_v == first) for (int i = 0; i < 7; i++) m_valid[k][i] = 1'b0;
            m_valid[k][c.edge_v - first] = 1'b1;
            m_samp[k][c.edge_v - first]  = c.rx;
          end
        end
        if (c.clr)                         m_cnt[k] = 0;
        else if (m_nf[k] && m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s nsamp=%0d cycle=%0d: observed %0h expected %0h", tag, ns_tab[k], cyc, obs, exp);
    end
  endtask

  task automatic check_all(input int presc);
    for (int k = 0; k < 3; k++) begin
      chk("sampled_bit", k, 32'(ob_bit[k]), 32'(m_bit[k]));
      chk("bit_ready",   k, 32'(ob_rdy[k]), 32'(m_rdy[k]));
      chk("noise_flag",  k, 32'(ob_nf[k]),  32'(m_nf[k]));
      chk("noise_cnt",   k, 32'(ob_cnt[k]), 32'(m_cnt[k]));
      chk("cfg_err",     k, 32'(ob_ce[k]),  32'(cfg_bad(presc, ns_tab[k])));
    end
  endtask

  initial begin
    logic [31:0] pat;
    int          p;
    int          prev;
    int          cut;
    int          clr_at;

    // Reset, then the directed scenarios.
    add_idle(2, 1'b0, 8);
    add_idle(3, 1'b1, 8);
    add_window(8, 32'h0000_0000, -1, -1);
    add_window(8, 32'h0000_0028, -1, -1);
    add_window(8, 32'h0000_0020, -1, -1);
    add_idle(1, 1'b1, 16);
    add_window(16, 32'h0000_0240, -1, -1);
    add_idle(1, 1'b1, 8);
    add_window(8, 32'hFFFF_FFFF, -1, -1);
    add_window(8, 32'h0000_0000, 4, -1);
    add_idle(1, 1'b1, 4);
    for (int i = 0; i < 3; i++) add_window(4, 32'($urandom), -1, -1);

    // Drive every counter into saturation, then clear on a noisy vote.
    add_idle(1, 1'b1, 8);
    for (int i = 0; i < 260; i++) begin
      pat    = $urandom;
      pat[4] = ~pat[3];
      add_window(8, pat, -1, -1);
    end
    pat    = $urandom;
    pat[4] = ~pat[3];
    add_window(8, pat, -1, 5);

    // Reset at edge 4 of a window, then a full window afterwards.
    for (int e = 0; e < 4; e++) push(1'b1, e, 1'($urandom), 1'b0, 1'b1, 8);
    push(1'b1, 4, 1'b0, 1'b0, 1'b0, 8);
    add_idle(1, 1'b0, 8);
    add_idle(3, 1'b1, 8);
    add_window(8, 32'h0000_0000, -1, -1);

    // Randomized bits over legal and illegal prescale values.
    prev = 8;
    for (int i = 0; i < 150; i++) begin
      p      = 2 * int'($urandom_range(1, 16));
      cut    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, p - 1)) : -1;
      clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, p - 1)) : -1;
      if (p != prev) add_idle(1, 1'b1, p);
      add_window(p, 32'($urandom), cut, clr_at);
      prev = p;
    end

    for (int t = 0; t < q.size(); t++) begin
      @(negedge CLK);
      RST              = q[t].rst_n;
      if3.data_samp_en = q[t].en; if5.data_samp_en = q[t].en; if7.data_samp_en = q[t].en;
      if3.edge_cnt     = 5'(q[t].edge_v); if5.edge_cnt = 5'(q[t].edge_v); if7.edge_cnt = 5'(q[t].edge_v);
      noise_clr        = q[t].clr;
      Prescale         = 6'(q[t].presc);
      // The synchronizer delays RX_IN by two clocks.
      RX_IN            = (t + 2 < q.size()) ? q[t+2].rx : 1'b1;
      @(posedge CLK);
      #1;
      cyc = t;
      model_step(q[t]);
      check_all(q[t].presc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
